// File: rtl/mc_rd_pack_ctrl.sv
// Read-packing sequencer: counts memory beats per bus width, issues pack latch
// enables and the word-valid strobe, and tracks words remaining in a read burst.
module mc_rd_pack_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      csc,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             clr,
   input  logic             mem_ack,
   output logic             pack_le0,
   output logic             pack_le1,
   output logic             pack_le2,
   output logic             dv,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] words_left,
   output logic             ack_err
);

   // state | meaning
   // IDLE  | no burst; start loads bus width and word count
   // PACK  | burst in progress; accepted acks advance the beat counter

   typedef enum logic {IDLE = 1'b0, PACK = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [1:0]       bw_q, bw_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic             err_q, err_d;
   logic             le0_q, le1_q, le2_q, dv_q, done_q;
   logic             le0_d, le1_d, le2_d, dv_d, done_d;

   logic             idle_like, take_start, acc, last_beat;
   logic [1:0]       cur_bw, cur_bcnt;
   logic [CNT_W-1:0] cur_words;

   logic unused_csc;
   assign unused_csc = ^{csc[31:6], csc[3:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bw_q    <= 2'd0;
         bcnt_q  <= 2'd0;
         words_q <= '0;
         err_q   <= 1'b0;
         le0_q   <= 1'b0;
         le1_q   <= 1'b0;
         le2_q   <= 1'b0;
         dv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bw_q    <= bw_d;
         bcnt_q  <= bcnt_d;
         words_q <= words_d;
         err_q   <= err_d;
         le0_q   <= le0_d;
         le1_q   <= le1_d;
         le2_q   <= le2_d;
         dv_q    <= dv_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bw_d       = bw_q;
      bcnt_d     = bcnt_q;
      words_d    = words_q;
      err_d      = err_q;
      le0_d      = 1'b0;
      le1_d      = 1'b0;
      le2_d      = 1'b0;
      dv_d       = 1'b0;
      done_d     = 1'b0;
      last_beat  = 1'b0;

      // A burst whose only word was finished by an ack in the start cycle
      // spends one cycle in PACK with no words left; treat that as idle.
      idle_like  = (state_q == IDLE) || (words_q == '0);
      take_start = start && idle_like && !clr;
      acc        = mem_ack && !clr && (take_start || !idle_like);

      cur_bw     = take_start ? csc[5:4] : bw_q;
      cur_bcnt   = take_start ? 2'd0 : bcnt_q;
      if (take_start)
         cur_words = (burst_len == '0) ? CNT_W'(1) : burst_len;
      else
         cur_words = words_q;

      case (cur_bw)
         2'd0:    last_beat = (cur_bcnt == 2'd3);
         2'd1:    last_beat = (cur_bcnt == 2'd1);
         default: last_beat = 1'b1;
      endcase

      if (acc) begin
         le0_d  = !last_beat && (cur_bcnt == 2'd0);
         le1_d  = (cur_bw == 2'd0) && (cur_bcnt == 2'd1);
         le2_d  = (cur_bw == 2'd0) && (cur_bcnt == 2'd2);
         dv_d   = last_beat;
         done_d = last_beat && (cur_words == CNT_W'(1));
      end

      if (clr) begin
         state_d = IDLE;
         bcnt_d  = 2'd0;
         words_d = '0;
      end else begin
         if (take_start) begin
            bw_d    = csc[5:4];
            bcnt_d  = 2'd0;
            words_d = cur_words;
            err_d   = 1'b0;
            state_d = PACK;
         end else if (mem_ack && idle_like) begin
            err_d = 1'b1;
         end

         if (acc) begin
            bcnt_d = last_beat ? 2'd0 : 2'(cur_bcnt + 2'd1);
            if (last_beat)
               words_d = cur_words - CNT_W'(1);
         end

         if (!take_start && state_q == PACK) begin
            if (idle_like || done_d)
               state_d = IDLE;
         end
      end
   end

   assign pack_le0   = le0_q;
   assign pack_le1   = le1_q;
   assign pack_le2   = le2_q;
   assign dv         = dv_q;
   assign done       = done_q;
   assign busy       = (state_q == PACK);
   assign words_left = words_q;
   assign ack_err    = err_q;

endmodule

// File: tb/tb_mc_rd_pack_ctrl.sv
// Directed, table-driven bench for mc_rd_pack_ctrl: one record per clock cycle
// holding that cycle's inputs and the registered outputs expected after the edge.
module tb_mc_rd_pack_ctrl;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [31:0]      csc = '0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] burst_len = '0;
   logic             clr = 1'b0;
   logic             mem_ack = 1'b0;
   logic             pack_le0, pack_le1, pack_le2, dv, busy, done, ack_err;
   logic [CNT_W-1:0] words_left;

   int n_tests = 0;
   int n_fail  = 0;

   mc_rd_pack_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .csc        (csc),
      .start      (start),
      .burst_len  (burst_len),
      .clr        (clr),
      .mem_ack    (mem_ack),
      .pack_le0   (pack_le0),
      .pack_le1   (pack_le1),
      .pack_le2   (pack_le2),
      .dv         (dv),
      .busy       (busy),
      .done       (done),
      .words_left (words_left),
      .ack_err    (ack_err)
   );

   always #5 clk = ~clk;

   // strb = {pack_le0, pack_le1, pack_le2, dv, done}
   typedef struct {
      logic             st;
      logic             cl;
      logic             ack;
      logic [1:0]       bw;
      logic [CNT_W-1:0] bl;
      logic [4:0]       strb;
      logic             bsy;
      logic [CNT_W-1:0] wl;
      logic             err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic cl, input logic ack,
                      input logic [1:0] bw, input logic [CNT_W-1:0] bl,
                      input logic [4:0] strb, input logic bsy,
                      input logic [CNT_W-1:0] wl, input logic err);
      vec_t v;
      v.st = st; v.cl = cl; v.ack = ack; v.bw = bw; v.bl = bl;
      v.strb = strb; v.bsy = bsy; v.wl = wl; v.err = err;
      vecs.push_back(v);
   endtask

   function automatic logic [14:0] pack_out();
      return {pack_le0, pack_le1, pack_le2, dv, done, busy, words_left, ack_err};
   endfunction

   task automatic check(input string name, input logic [14:0] exp);
      logic [14:0] act;
      act = pack_out();
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got le0/le1/le2/dv/done=%b busy=%b wl=%0d err=%b, want le0/le1/le2/dv/done=%b busy=%b wl=%0d err=%b",
                  name, act[14:10], act[9], act[8:1], act[0], exp[14:10], exp[9], exp[8:1], exp[0]);
      end
   endtask

   initial begin
      // test 1: 8-bit, 2 words, 8 back-to-back acks
      add(1,0,1, 0,2, 5'b10000,1,2,0);
      add(0,0,1, 0,2, 5'b01000,1,2,0);
      add(0,0,1, 0,2, 5'b00100,1,2,0);
      add(0,0,1, 0,2, 5'b00010,1,1,0);
      add(0,0,1, 0,2, 5'b10000,1,1,0);
      add(0,0,1, 0,2, 5'b01000,1,1,0);
      add(0,0,1, 0,2, 5'b00100,1,1,0);
      add(0,0,1, 0,2, 5'b00011,0,0,0);
      add(0,0,0, 0,2, 5'b00000,0,0,0);
      // test 2: 16-bit, 3 words, ack every other cycle
      add(1,0,0, 1,3, 5'b00000,1,3,0);
      add(0,0,1, 1,3, 5'b10000,1,3,0);
      add(0,0,0, 1,3, 5'b00000,1,3,0);
      add(0,0,1, 1,3, 5'b00010,1,2,0);
      add(0,0,0, 1,3, 5'b00000,1,2,0);
      add(0,0,1, 1,3, 5'b10000,1,2,0);
      add(0,0,0, 1,3, 5'b00000,1,2,0);
      add(0,0,1, 1,3, 5'b00010,1,1,0);
      add(0,0,0, 1,3, 5'b00000,1,1,0);
      add(0,0,1, 1,3, 5'b10000,1,1,0);
      add(0,0,0, 1,3, 5'b00000,1,1,0);
      add(0,0,1, 1,3, 5'b00011,0,0,0);
      // test 3: 32-bit, burst_len 0, start+ack right after done
      add(1,0,1, 2,0, 5'b00011,1,0,0);
      add(0,0,0, 2,0, 5'b00000,0,0,0);
      // test 4: 8-bit, 4 words, clr with the 7th ack, then fresh 1-word burst
      add(1,0,1, 0,4, 5'b10000,1,4,0);
      add(0,0,1, 0,4, 5'b01000,1,4,0);
      add(0,0,1, 0,4, 5'b00100,1,4,0);
      add(0,0,1, 0,4, 5'b00010,1,3,0);
      add(0,0,1, 0,4, 5'b10000,1,3,0);
      add(0,0,1, 0,4, 5'b01000,1,3,0);
      add(0,1,1, 0,4, 5'b00000,0,0,0);
      add(1,0,0, 0,1, 5'b00000,1,1,0);
      add(0,0,1, 0,1, 5'b10000,1,1,0);
      add(0,0,1, 0,1, 5'b01000,1,1,0);
      add(0,0,1, 0,1, 5'b00100,1,1,0);
      add(0,0,1, 0,1, 5'b00011,0,0,0);
      // test 5: csc goes to 32-bit mid-burst; also a start in PACK is ignored
      add(1,0,1, 0,1, 5'b10000,1,1,0);
      add(0,0,1, 2,1, 5'b01000,1,1,0);
      add(1,0,1, 2,9, 5'b00100,1,1,0);
      add(0,0,1, 2,1, 5'b00011,0,0,0);
      // test 6: clr+ack idle (no error), idle ack sets sticky error, start clears
      add(0,1,1, 0,1, 5'b00000,0,0,0);
      add(0,0,1, 0,1, 5'b00000,0,0,1);
      add(0,0,0, 0,1, 5'b00000,0,0,1);
      add(1,0,0, 2,1, 5'b00000,1,1,0);
      add(0,0,1, 2,1, 5'b00011,0,0,0);

      #12;
      check("reset_state", 15'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         start     = vecs[i].st;
         clr       = vecs[i].cl;
         mem_ack   = vecs[i].ack;
         csc       = {26'd0, vecs[i].bw, 4'd0};
         burst_len = vecs[i].bl;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i),
               {vecs[i].strb, vecs[i].bsy, vecs[i].wl, vecs[i].err});
      end

      // async reset mid-burst, between clock edges
      @(negedge clk);
      start = 1'b1; mem_ack = 1'b1; clr = 1'b0;
      csc = 32'h0; burst_len = 8'd3;
      @(posedge clk);
      #1;
      check("pre_reset_burst", {5'b10000, 1'b1, 8'd3, 1'b0});
      start = 1'b0; mem_ack = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", 15'd0);
      @(posedge clk);
      #1;
      check("reset_held", 15'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
